rf_write_sched: RTL and testbench

Write-port scheduler for the 32×32 three-port register file (`regfile`: two read ports, one write port `we3`/`wa3`/`wd3`). It shares the single write port between two writeback requesters, such as the ALU and the load path, using valid/ready handshakes and round-robin arbitration. After reset it sequences a clear of every architectural register. It sits directly in front of `regfile`, and its outputs drive `we3`, `wa3` and `wd3`.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_write_sched_rr_arb2.sv | 20 ++
 rtl/rf_write_sched.sv | 103 ++++++++++
 tb/tb_rf_write_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and state type for the register-file write scheduler.
package rf_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef enum logic {CLEAR, RUN} rf_sched_state_t;

endpackage

// File: rtl/rf_write_sched_rr_arb2.sv
// Two-way round-robin arbiter. The priority pointer lives in the parent; when
// both requesters are active, the one that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Combinational grant: a lone requester always wins; on contention, rotate.
    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/rf_write_sched.sv
// Write-port scheduler for the 3-port register file. After reset it clears
// registers 1..NREG-1, then shares the single write port between two
// valid/ready requesters with round-robin arbitration.
module rf_write_sched
    import rf_pkg::*;
#(
    parameter int NREG           = rf_pkg::NREG,
    parameter int AW             = rf_pkg::AW,
    parameter int DW             = rf_pkg::DW,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic          init_done
);

    rf_sched_state_t state;
    logic [AW-1:0]   cnt;
    logic            last;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic [1:0]      rdy;
    logic            runOk;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;

    assign req = {req1_valid, req0_valid};

    rr_arb2 uArb (
        .req  (req),
        .last (last),
        .gnt  (gnt)
    );

    // Grants are only exposed in RUN and never while reset is held.
    always_comb begin
        runOk   = (state == RUN) && !reset;
        rdy     = runOk ? gnt : '0;
        selAddr = rdy[1] ? req1_addr : req0_addr;
        selData = rdy[1] ? req1_data : req0_data;
    end

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];

    // Clear sequencing, pointer update and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt       <= AW'(1);
            last      <= 1'b1;
            we3       <= 1'b0;
            wa3       <= '0;
            wd3       <= '0;
            init_done <= !CLEAR_ON_RESET;
        end else begin
            case (state)
                CLEAR: begin
                    we3 <= 1'b1;
                    wa3 <= cnt;
                    wd3 <= '0;
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(NREG - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (|rdy) begin
                        last <= rdy[1];
                        // Address 0 is acknowledged but dropped; wa3/wd3 hold.
                        if (selAddr != '0) begin
                            we3 <= 1'b1;
                            wa3 <= selAddr;
                            wd3 <= selData;
                        end else begin
                            we3 <= 1'b0;
                        end
                    end else begin
                        we3 <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    we3   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: a reference arbiter and a
// behavioural regfile drive a scoreboard of expected write-port activity.
module tb_rf_write_sched;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic          init_done;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;

    wr_t           expQ[$];
    logic          mLast;
    logic [AW-1:0] heldA;
    logic [DW-1:0] heldD;

    logic [DW-1:0] rfMem [32] = '{default: '0};

    rf_write_sched #(
        .NREG(32), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Behavioural regfile: writes any address so a stray write to r0 is visible.
    always @(posedge clk) begin
        if (we3) rfMem[wa3] <= wd3;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus: check ready against the reference arbiter, then
    // check the write port against the scoreboard after the edge.
    task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input string tag);
        logic [1:0] eg;
        wr_t w;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        if (v0 && v1) eg = mLast ? 2'b01 : 2'b10;
        else          eg = {v1, v0};
        vectors++;
        if ({req1_ready, req0_ready} !== eg) begin
            miscompares++;
            $display("FAIL %s ready: got %b want %b", tag, {req1_ready, req0_ready}, eg);
        end
        if (eg != 2'b00) begin
            mLast = eg[1];
            w.a = eg[1] ? a1 : a0;
            w.d = eg[1] ? d1 : d0;
            if (w.a != '0) expQ.push_back(w);
        end
        @(posedge clk); #1;
        vectors++;
        if (expQ.size() > 0) begin
            w = expQ.pop_front();
            if ({we3, wa3, wd3} !== {1'b1, w.a, w.d}) begin
                miscompares++;
                $display("FAIL %s write: got we3=%b wa3=%0d wd3=%h want we3=1 wa3=%0d wd3=%h",
                         tag, we3, wa3, wd3, w.a, w.d);
            end
            heldA = w.a;
            heldD = w.d;
        end else begin
            if ({we3, wa3, wd3} !== {1'b0, heldA, heldD}) begin
                miscompares++;
                $display("FAIL %s idle: got we3=%b wa3=%0d wd3=%h want we3=0 wa3=%0d wd3=%h",
                         tag, we3, wa3, wd3, heldA, heldD);
            end
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, '0, 1'b0, '0, '0, tag);
    endtask

    task automatic checkReg(input int unsigned r, input logic [DW-1:0] want, input string tag);
        vectors++;
        if (rfMem[r] !== want) begin
            miscompares++;
            $display("FAIL %s regfile r%0d: got %h want %h", tag, r, rfMem[r], want);
        end
    endtask

    // Clear sequence after reset; requesters stay valid to prove ready is gated.
    task automatic test_reset_clear();
        reset = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h1111_1111;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h2222_2222;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({we3, wa3, wd3, init_done, req1_ready, req0_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset state: got we3=%b wa3=%0d wd3=%h init_done=%b ready=%b%b want all 0",
                     we3, wa3, wd3, init_done, req1_ready, req0_ready);
        end
        reset = 1'b0;
        for (int unsigned k = 1; k <= 31; k++) begin
            #1;
            vectors++;
            if ({req1_ready, req0_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL clear ready @%0d: got %b want 00", k, {req1_ready, req0_ready});
            end
            @(posedge clk); #1;
            vectors++;
            if ({we3, wa3, wd3} !== {1'b1, AW'(k), 32'h0}) begin
                miscompares++;
                $display("FAIL clear write @%0d: got we3=%b wa3=%0d wd3=%h want we3=1 wa3=%0d wd3=0",
                         k, we3, wa3, wd3, k);
            end
            vectors++;
            if (init_done !== (k == 31)) begin
                miscompares++;
                $display("FAIL clear init_done @%0d: got %b want %b", k, init_done, (k == 31));
            end
        end
        mLast = 1'b1;
        heldA = 5'd31;
        heldD = '0;
        expQ.delete();
    endtask

    task automatic test_single();
        step(1'b1, 5'd5, 32'h0000_000C, 1'b0, '0, '0, "single");
        idle("single_land");
        checkReg(5, 32'h0000_000C, "single");
    endtask

    task automatic test_addr0();
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, "addr0");
        idle("addr0_land");
        checkReg(0, 32'h0, "addr0");
    endtask

    task automatic test_contention();
        for (int unsigned i = 0; i < 4; i++)
            step(1'b1, 5'd2, 32'hA, 1'b1, 5'd3, 32'hB, $sformatf("contend%0d", i));
        idle("contend_land");
        checkReg(2, 32'hA, "contend");
        checkReg(3, 32'hB, "contend");
    endtask

    task automatic test_same_addr();
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, "same0");
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'h2, "same1");
        idle("same_land");
        checkReg(7, 32'h2, "same");
    endtask

    task automatic test_mid_reset();
        step(1'b1, 5'd9, 32'h55, 1'b0, '0, '0, "pre_reset");
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h77;
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset ready: got %b want 00", {req1_ready, req0_ready});
        end
        @(posedge clk); #1;
        vectors++;
        if ({we3, init_done, wa3, wd3} !== '0) begin
            miscompares++;
            $display("FAIL midreset state: got we3=%b init_done=%b wa3=%0d wd3=%h want all 0",
                     we3, init_done, wa3, wd3);
        end
        reset = 1'b0;
        req1_valid = 1'b0;
        for (int unsigned k = 1; k <= 2; k++) begin
            @(posedge clk); #1;
            vectors++;
            if ({we3, wa3, wd3, init_done} !== {1'b1, AW'(k), 32'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL midreset clear @%0d: got we3=%b wa3=%0d wd3=%h init_done=%b want 1/%0d/0/0",
                         k, we3, wa3, wd3, init_done, k);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        mLast = 1'b1; heldA = '0; heldD = '0;
        test_reset_clear();
        test_single();
        test_addr0();
        test_contention();
        test_same_addr();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
